fm_mod32: RTL and testbench

FM_MOD32 -- requirements
Module: fm_mod32

---
 rtl/fm_pkg.sv | 32 +++
 rtl/fm_sin_rom.sv | 31 +++
 rtl/fm_mod32.sv | 120 ++++++++++++
 tb/tb_fm_mod32.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_pkg.sv
// Shared widths, IQ beat packing and the quarter-wave fold used by the FM modulator.
package fm_pkg;

    localparam int PHASE_W    = 32;
    localparam int LUT_ADDR_W = 10;
    localparam int IQ_W       = 16;
    localparam int AMP        = 32767;
    localparam int ROM_DEPTH  = 257;
    localparam int ROM_AW     = 9;

    // Field order matches tdata: Q in [31:16], I in [15:0].
    typedef struct packed {
        logic signed [IQ_W-1:0] q;
        logic signed [IQ_W-1:0] i;
    } iq_t;

    typedef struct packed {
        logic              neg;
        logic [ROM_AW-1:0] addr;
    } lut_sel_t;

    // Odd quadrants read the table mirrored, the upper half of the circle negates.
    function automatic lut_sel_t fold_index(input logic [LUT_ADDR_W-1:0] x);
        lut_sel_t          s;
        logic [ROM_AW-1:0] k;
        k      = {1'b0, x[7:0]};
        s.neg  = x[9];
        s.addr = x[8] ? (ROM_AW'(256) - k) : k;
        return s;
    endfunction

endpackage

// File: rtl/fm_sin_rom.sv
// Quarter-wave sine magnitude table (257 entries, 0..AMP) with one registered read port.
module fm_sin_rom
    import fm_pkg::*;
(
    input  logic              clk,
    input  logic              en,
    input  logic [ROM_AW-1:0] addr,
    output logic [IQ_W-1:0]   data
);

    localparam real PI = 3.14159265358979323846;

    function automatic logic [IQ_W-1:0] rom_entry(input int j);
        real v;
        v = real'(AMP) * $sin(PI * real'(j) / 512.0);
        return IQ_W'($rtoi(v + 0.5));
    endfunction

    logic [IQ_W-1:0] rom [ROM_DEPTH];

    for (genvar j = 0; j < ROM_DEPTH; j++) begin : g_rom
        assign rom[j] = rom_entry(j);
    end

    always_ff @(posedge clk) begin
        if (en) begin
            data <= rom[addr];
        end
    end

endmodule

// File: rtl/fm_mod32.sv
// FM modulator: audio samples drive a phase accumulator whose phase is mapped to
// a quarter-wave sine table to produce packed {Q, I} beats.
module fm_mod32
    import fm_pkg::*;
#(
    parameter int          DEV_SHIFT  = 14,
    parameter logic [31:0] CENTER_INC = 32'h0
) (
    input  logic        s00_axis_aclk,
    input  logic        s00_axis_areset,
    input  logic        s00_axis_tvalid,
    input  logic [31:0] s00_axis_tdata,
    input  logic        s00_axis_tlast,
    input  logic [3:0]  s00_axis_tstrb,
    output logic        s00_axis_tready,
    input  logic        m00_axis_tready,
    output logic        m00_axis_tvalid,
    output logic [31:0] m00_axis_tdata,
    output logic        m00_axis_tlast,
    output logic [3:0]  m00_axis_tstrb
);

    logic                  advance;
    logic                  accept;
    logic [PHASE_W-1:0]    audio_ext;
    logic [PHASE_W-1:0]    inc;
    logic [PHASE_W-1:0]    phase_next;
    logic [PHASE_W-1:0]    phase_acc;
    logic                  s1_valid;
    logic                  s1_tlast;
    logic [LUT_ADDR_W-1:0] s1_p;
    logic [LUT_ADDR_W-1:0] p_i;
    logic                  s2_valid;
    logic                  s2_tlast;
    lut_sel_t              s2_sel_q;
    lut_sel_t              s2_sel_i;
    logic                  s3_valid;
    logic                  s3_tlast;
    logic                  s3_neg_q;
    logic                  s3_neg_i;
    logic [IQ_W-1:0]       rom_q;
    logic [IQ_W-1:0]       rom_i;
    iq_t                   iq_next;
    logic                  unused_ok;

    // Handshake: a beat moves on an edge where valid && ready. The whole pipe
    // advances together whenever the output register is empty or being drained,
    // and input ready is exactly that advance condition.
    assign advance         = m00_axis_tready | ~m00_axis_tvalid;
    assign s00_axis_tready = advance;
    assign accept          = s00_axis_tvalid & advance & ~s00_axis_areset;

    assign audio_ext  = {{(PHASE_W-16){s00_axis_tdata[15]}}, s00_axis_tdata[15:0]};
    assign inc        = (audio_ext << DEV_SHIFT) + CENTER_INC;
    assign phase_next = phase_acc + inc;
    assign p_i        = s1_p + LUT_ADDR_W'(256);

    assign m00_axis_tstrb = m00_axis_tvalid ? 4'hF : 4'h0;
    assign unused_ok      = ^{s00_axis_tdata[31:16], s00_axis_tstrb};

    // Table reads are enabled with advance so the ROM registers stall with the pipe.
    fm_sin_rom u_rom_q (
        .clk  (s00_axis_aclk),
        .en   (advance),
        .addr (s2_sel_q.addr),
        .data (rom_q)
    );

    fm_sin_rom u_rom_i (
        .clk  (s00_axis_aclk),
        .en   (advance),
        .addr (s2_sel_i.addr),
        .data (rom_i)
    );

    always_comb begin
        iq_next   = '0;
        iq_next.q = s3_neg_q ? (IQ_W'(0) - rom_q) : rom_q;
        iq_next.i = s3_neg_i ? (IQ_W'(0) - rom_i) : rom_i;
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            phase_acc       <= '0;
            s1_valid        <= 1'b0;
            s1_tlast        <= 1'b0;
            s1_p            <= '0;
            s2_valid        <= 1'b0;
            s2_tlast        <= 1'b0;
            s2_sel_q        <= '0;
            s2_sel_i        <= '0;
            s3_valid        <= 1'b0;
            s3_tlast        <= 1'b0;
            s3_neg_q        <= 1'b0;
            s3_neg_i        <= 1'b0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tdata  <= '0;
        end else if (advance) begin
            if (accept) begin
                phase_acc <= phase_next;
            end
            s1_valid        <= accept;
            s1_tlast        <= accept & s00_axis_tlast;
            s1_p            <= phase_next[PHASE_W-1 -: LUT_ADDR_W];
            s2_valid        <= s1_valid;
            s2_tlast        <= s1_tlast;
            s2_sel_q        <= fold_index(s1_p);
            s2_sel_i        <= fold_index(p_i);
            s3_valid        <= s2_valid;
            s3_tlast        <= s2_tlast;
            s3_neg_q        <= s2_sel_q.neg;
            s3_neg_i        <= s2_sel_i.neg;
            m00_axis_tvalid <= s3_valid;
            m00_axis_tlast  <= s3_tlast;
            m00_axis_tdata  <= iq_next;
        end
    end

endmodule

// File: tb/tb_fm_mod32.sv
// Bench for fm_mod32: two instances (baseband and offset carrier) fed the same
// stream, checked against a trigonometric model of the modulator.
module tb_fm_mod32;

    localparam real         PI      = 3.14159265358979323846;
    localparam int          SHIFT_A = 16;
    localparam logic [31:0] CINC_A  = 32'h0;
    localparam int          SHIFT_B = 14;
    localparam logic [31:0] CINC_B  = 32'h0123_4567;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic [3:0]  in_strb;
    logic        out_ready;
    logic        ready_a, ready_b, valid_a, valid_b, last_a, last_b;
    logic [31:0] data_a, data_b;
    logic [3:0]  strb_a, strb_b;

    always #5 clk = ~clk;

    fm_mod32 #(.DEV_SHIFT(SHIFT_A), .CENTER_INC(CINC_A)) dut_a (
        .s00_axis_aclk(clk), .s00_axis_areset(rst), .s00_axis_tvalid(in_valid),
        .s00_axis_tdata(in_data), .s00_axis_tlast(in_last), .s00_axis_tstrb(in_strb),
        .s00_axis_tready(ready_a), .m00_axis_tready(out_ready), .m00_axis_tvalid(valid_a),
        .m00_axis_tdata(data_a), .m00_axis_tlast(last_a), .m00_axis_tstrb(strb_a)
    );

    fm_mod32 #(.DEV_SHIFT(SHIFT_B), .CENTER_INC(CINC_B)) dut_b (
        .s00_axis_aclk(clk), .s00_axis_areset(rst), .s00_axis_tvalid(in_valid),
        .s00_axis_tdata(in_data), .s00_axis_tlast(in_last), .s00_axis_tstrb(in_strb),
        .s00_axis_tready(ready_b), .m00_axis_tready(out_ready), .m00_axis_tvalid(valid_b),
        .m00_axis_tdata(data_b), .m00_axis_tlast(last_b), .m00_axis_tstrb(strb_b)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] phase_a, phase_b;
    logic [32:0] exp_a[$], exp_b[$], got_a[$], got_b[$];
    logic [15:0] src_audio[$];
    logic        src_last[$];
    int          acc_cyc[$], out_cyc[$];
    logic [31:0] trace_d[$];
    logic        trace_v[$], trace_r[$];

    // ---------------- reference model ----------------
    function automatic logic [15:0] round_amp(input real s);
        real v;
        v = 32767.0 * s;
        if (v >= 0.0) return 16'($rtoi(v + 0.5));
        return 16'(-$rtoi(-v + 0.5));
    endfunction

    function automatic logic [31:0] iq_of(input logic [31:0] phase);
        real ang;
        ang = 2.0 * PI * real'(phase[31:22]) / 1024.0;
        return {round_amp($sin(ang)), round_amp($cos(ang))};
    endfunction

    task automatic model_reset();
        phase_a = '0;
        phase_b = '0;
        exp_a.delete();
        exp_b.delete();
        src_audio.delete();
        src_last.delete();
    endtask

    task automatic queue_beat(input logic [15:0] audio, input logic last);
        longint s;
        s = longint'($signed(audio));
        phase_a = phase_a + 32'(s * (longint'(1) << SHIFT_A)) + CINC_A;
        phase_b = phase_b + 32'(s * (longint'(1) << SHIFT_B)) + CINC_B;
        exp_a.push_back({last, iq_of(phase_a)});
        exp_b.push_back({last, iq_of(phase_b)});
        src_audio.push_back(audio);
        src_last.push_back(last);
    endtask

    // ---------------- clock/reset and driver ----------------
    task automatic reset_dut();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        model_reset();
    endtask

    // rdy_mode: 0 always ready, 1 ready low for a window, 2 random ready.
    task automatic pump(input int rdy_mode, input int stall_at, input int stall_len,
                        input int gap_pct, input int max_cyc);
        int cyc;
        int want;
        bit presenting;
        cyc = 0; want = exp_a.size(); presenting = 0;
        got_a.delete(); got_b.delete(); acc_cyc.delete(); out_cyc.delete();
        trace_d.delete(); trace_v.delete(); trace_r.delete();
        @(posedge clk); #1;
        while ((src_audio.size() > 0 || got_a.size() < want) && cyc < max_cyc) begin
            if (!presenting && src_audio.size() > 0 && $urandom_range(99) >= gap_pct)
                presenting = 1;
            in_valid = presenting;
            in_strb  = 4'($urandom);
            if (presenting) begin
                in_data = {16'($urandom), src_audio[0]};
                in_last = src_last[0];
            end else begin
                in_data = $urandom;
                in_last = 1'($urandom);
            end
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
                default: out_ready = ($urandom_range(3) != 0);
            endcase
            @(negedge clk);
            trace_v.push_back(valid_a); trace_d.push_back(data_a); trace_r.push_back(out_ready);
            if (valid_a && out_ready) begin
                got_a.push_back({last_a, data_a});
                out_cyc.push_back(cyc);
            end
            if (valid_b && out_ready) got_b.push_back({last_b, data_b});
            if (presenting && ready_a) begin
                acc_cyc.push_back(cyc);
                void'(src_audio.pop_front());
                void'(src_last.pop_front());
                presenting = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (cyc >= max_cyc) begin
            errors++;
            $display("FAIL pump_budget cycles %0d limit %0d got %0d want %0d", cyc, max_cyc, got_a.size(), want);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 32'h0000_4000; in_last = 1'b1; out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++;
        if (valid_a !== 1'b0 || valid_b !== 1'b0) begin
            errors++; $display("FAIL reset_tvalid got %b/%b want 0/0", valid_a, valid_b);
        end
        checks++;
        if (last_a !== 1'b0 || last_b !== 1'b0) begin
            errors++; $display("FAIL reset_tlast got %b/%b want 0/0", last_a, last_b);
        end
        checks++;
        if (data_a !== 32'h0 || data_b !== 32'h0) begin
            errors++; $display("FAIL reset_tdata got %h/%h want 0", data_a, data_b);
        end
        checks++;
        if (strb_a !== 4'h0 || strb_b !== 4'h0) begin
            errors++; $display("FAIL reset_tstrb got %h/%h want 0", strb_a, strb_b);
        end
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        model_reset();
        // The beat held during reset must not have advanced the phase.
        queue_beat(16'h4000, 1'b0);
        pump(0, 0, 0, 0, 100);
        checks++;
        if (got_a.size() != 1 || got_a[0] !== {1'b0, 32'h7FFF_0000}) begin
            errors++; $display("FAIL reset_first_beat got %h want %h", got_a.size() > 0 ? got_a[0] : 33'h0, {1'b0, 32'h7FFF_0000});
        end
        checks++;
        if (got_b.size() != 1 || got_b[0] !== exp_b[0]) begin
            errors++; $display("FAIL reset_first_beat_b got %0d beats want %h", got_b.size(), exp_b[0]);
        end
        checks++;
        if (strb_a !== 4'h0) begin
            errors++; $display("FAIL idle_tstrb got %h want 0", strb_a);
        end
    endtask

    task automatic test_zero_audio();
        reset_dut();
        repeat (3) queue_beat(16'h0000, 1'b0);
        pump(0, 0, 0, 0, 100);
        checks++;
        if (got_a.size() != 3 || got_b.size() != 3) begin
            errors++; $display("FAIL zero_count got %0d/%0d want 3", got_a.size(), got_b.size());
        end
        for (int i = 0; i < got_a.size() && i < 3; i++) begin
            checks++;
            if (got_a[i] !== {1'b0, 32'h0000_7FFF}) begin
                errors++; $display("FAIL zero_iq beat %0d got %h want %h", i, got_a[i], {1'b0, 32'h0000_7FFF});
            end
            checks++;
            if (got_b[i] !== exp_b[i]) begin
                errors++; $display("FAIL zero_iq_b beat %0d got %h want %h", i, got_b[i], exp_b[i]);
            end
            // Sample points are one per cycle: valid shows after the third edge past acceptance.
            checks++;
            if (out_cyc[i] - acc_cyc[i] != 4) begin
                errors++; $display("FAIL zero_latency beat %0d got %0d want 4", i, out_cyc[i] - acc_cyc[i]);
            end
        end
    endtask

    task automatic test_quarter_steps();
        logic [31:0] want [5];
        want[0] = 32'h7FFF_0000; want[1] = 32'h0000_8001; want[2] = 32'h8001_0000;
        want[3] = 32'h0000_7FFF; want[4] = 32'h7FFF_0000;
        reset_dut();
        repeat (5) queue_beat(16'h4000, 1'b0);
        pump(0, 0, 0, 0, 100);
        checks++;
        if (got_a.size() != 5) begin
            errors++; $display("FAIL quarter_count got %0d want 5", got_a.size());
        end
        for (int i = 0; i < got_a.size() && i < 5; i++) begin
            checks++;
            if (got_a[i] !== {1'b0, want[i]}) begin
                errors++; $display("FAIL quarter_iq beat %0d got %h want %h", i, got_a[i], want[i]);
            end
            checks++;
            if (got_b[i] !== exp_b[i]) begin
                errors++; $display("FAIL quarter_iq_b beat %0d got %h want %h", i, got_b[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_stall();
        int held;
        held = 0;
        reset_dut();
        for (int i = 0; i < 10; i++) queue_beat(16'($urandom), 1'b0);
        pump(1, 5, 5, 0, 200);
        for (int i = 1; i < trace_v.size(); i++) begin
            if (trace_v[i-1] && !trace_r[i-1]) begin
                held++;
                checks++;
                if (trace_v[i] !== 1'b1 || trace_d[i] !== trace_d[i-1]) begin
                    errors++; $display("FAIL stall_hold cycle %0d got %b/%h want 1/%h", i, trace_v[i], trace_d[i], trace_d[i-1]);
                end
            end
        end
        checks++;
        if (held < 5 || got_a.size() != 10 || got_b.size() != 10) begin
            errors++; $display("FAIL stall_count held %0d got %0d/%0d want >=5 and 10", held, got_a.size(), got_b.size());
        end
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
            checks++;
            if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i]) begin
                errors++; $display("FAIL stall_order beat %0d got %h/%h want %h/%h", i, got_a[i], got_b[i], exp_a[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_tlast();
        reset_dut();
        for (int i = 0; i < 6; i++) queue_beat(16'($urandom), i == 3);
        pump(0, 0, 0, 0, 100);
        checks++;
        if (got_a.size() != 6) begin
            errors++; $display("FAIL tlast_count got %0d want 6", got_a.size());
        end
        for (int i = 0; i < got_a.size() && i < 6; i++) begin
            checks++;
            if (got_a[i][32] !== (i == 3) || got_b[i][32] !== (i == 3)) begin
                errors++; $display("FAIL tlast_flag beat %0d got %b/%b want %b", i, got_a[i][32], got_b[i][32], i == 3);
            end
            checks++;
            if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i]) begin
                errors++; $display("FAIL tlast_iq beat %0d got %h/%h want %h/%h", i, got_a[i], got_b[i], exp_a[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        bit seen;
        seen = 0;
        reset_dut();
        in_valid = 1'b1; in_data = 32'h0000_1234; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        in_data = 32'h0000_4321;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | valid_a | valid_b;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL midreset_flush got valid 1 want 0");
        end
        model_reset();
        queue_beat(16'h0000, 1'b0);
        pump(0, 0, 0, 0, 100);
        checks++;
        if (got_a.size() != 1 || got_a[0] !== {1'b0, 32'h0000_7FFF}) begin
            errors++; $display("FAIL midreset_restart got %0d beats want %h", got_a.size(), {1'b0, 32'h0000_7FFF});
        end
        checks++;
        if (got_b.size() != 1 || got_b[0] !== exp_b[0]) begin
            errors++; $display("FAIL midreset_restart_b got %0d beats want %h", got_b.size(), exp_b[0]);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        reset_dut();
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(9))
                0:       a = 16'h8000;
                1:       a = 16'h7FFF;
                2:       a = 16'hFFFF;
                default: a = 16'($urandom);
            endcase
            queue_beat(a, ($urandom_range(7) == 0));
        end
        pump(2, 0, 0, 20, 5000);
        checks++;
        if (got_a.size() != 150 || got_b.size() != 150) begin
            errors++; $display("FAIL random_count got %0d/%0d want 150", got_a.size(), got_b.size());
        end
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
            checks++;
            if (got_a[i] !== exp_a[i]) begin
                errors++; $display("FAIL random_a beat %0d got %h want %h", i, got_a[i], exp_a[i]);
            end
        end
        for (int i = 0; i < got_b.size() && i < exp_b.size(); i++) begin
            checks++;
            if (got_b[i] !== exp_b[i]) begin
                errors++; $display("FAIL random_b beat %0d got %h want %h", i, got_b[i], exp_b[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_strb = '0; out_ready = 1'b1;
        phase_a = '0; phase_b = '0;
        test_reset();
        test_zero_audio();
        test_quarter_steps();
        test_stall();
        test_tlast();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
